// File: rtl/demux.sv
// demux: registered 1-to-N demultiplexer with valid/ready handshake.
// One word is held at a time together with its destination index. The word is
// presented only to its selected destination, and only that destination's
// out_ready can take it. A held word can drain and a new word can be accepted
// in the same cycle, so the stream runs at one word per cycle when the sink is
// ready. A word whose index has no destination (possible only when OUTPUTS is
// not a power of two) is accepted and discarded. The discard raises err for one
// cycle and bumps a saturating drop counter.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   input word present
//   in_ready   input word accepted this cycle
//   in_data    input word [DATA_WIDTH]
//   addr       destination index [ADDR_WIDTH], sampled with in_data
//   outputs    per-destination data, zero when that destination is not valid
//   out_valid  one-hot valid [OUTPUTS]
//   out_ready  per-destination ready [OUTPUTS]
//   err        one-cycle pulse after an out-of-range word was dropped
//   drop_cnt   saturating count of dropped words [8]
module demux #(
  parameter  int DATA_WIDTH = 8,
  parameter  int OUTPUTS    = 4,
  localparam int ADDR_WIDTH = $clog2(OUTPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] outputs [OUTPUTS],
  output logic [OUTPUTS-1:0]    out_valid,
  input  logic [OUTPUTS-1:0]    out_ready,
  output logic                  err,
  output logic [7:0]            drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // One extra bit so the bound is representable when OUTPUTS is a power of two.
  localparam logic [ADDR_WIDTH:0] OUT_N = (ADDR_WIDTH+1)'(OUTPUTS);

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  err_q;
  logic [7:0]            drop_q;

  logic [OUTPUTS-1:0]    sel_oh;
  logic                  sel_ready;
  logic                  addr_ok;
  logic                  in_xfer;
  logic                  out_xfer;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // One-hot decode of the held index; out_ready is read only through it so
  // non-selected ready bits have no effect.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      sel_oh[i] = (addr_q == ADDR_WIDTH'(i));
    end
  end

  assign sel_ready = |(sel_oh & out_ready);
  assign addr_ok   = ({1'b0, addr} < OUT_N);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = (state_q == FULL) && sel_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. In FULL an input transfer implies the held word drains in the
  // same cycle, so the new word alone decides the next state.
  always_comb begin
    state_d = state_q;
    if (in_xfer) begin
      state_d = addr_ok ? FULL : EMPTY;
    end else if (out_xfer) begin
      state_d = EMPTY;
    end
  end

  // Held word, error pulse and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      err_q <= in_xfer && !addr_ok;
      if (in_xfer && addr_ok) begin
        data_q <= in_data;
        addr_q <= addr;
      end
      if (in_xfer && !addr_ok) begin
        drop_q <= sat_inc8(drop_q);
      end
    end
  end

  // Outputs; everything handshake-facing is forced low while rst is high.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      outputs[i] = '0;
    end
    if (!rst) begin
      in_ready = (state_q == EMPTY) || sel_ready;
      if (state_q == FULL) begin
        out_valid = sel_oh;
      end
      for (int i = 0; i < OUTPUTS; i++) begin
        outputs[i] = out_valid[i] ? data_q : '0;
      end
    end
  end

  assign err      = err_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux.sv
// Bench for demux: a 4-destination instance driven through directed and random
// sequences against a queue-based model, plus a 3-destination instance for the
// out-of-range drop path and counter saturation.
module tb_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-destination instance
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [1:0] addr = '0;
  logic [7:0] outs4 [4];
  logic [3:0] out_valid;
  logic [3:0] out_ready = '0;
  logic       err;
  logic [7:0] drop_cnt;

  demux #(.DATA_WIDTH(8), .OUTPUTS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .addr(addr),
    .outputs(outs4), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .drop_cnt(drop_cnt)
  );

  // 3-destination instance
  logic       iv3 = 1'b0;
  logic       ir3;
  logic [7:0] d3 = '0;
  logic [1:0] a3 = '0;
  logic [7:0] o3 [3];
  logic [2:0] ov3;
  logic [2:0] r3 = '0;
  logic       err3;
  logic [7:0] dc3;

  demux #(.DATA_WIDTH(8), .OUTPUTS(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(iv3), .in_ready(ir3), .in_data(d3), .addr(a3),
    .outputs(o3), .out_valid(ov3), .out_ready(r3),
    .err(err3), .drop_cnt(dc3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of the 4-destination instance: words accepted but not yet delivered,
  // in acceptance order.
  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } word_t;
  word_t q[$];

  // One cycle on dut4: drive, check at the falling edge, then advance the
  // model across the rising edge. Called just after a rising edge.
  task automatic step4(input logic v, input logic [1:0] a, input logic [7:0] d,
                       input logic [3:0] r);
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic [7:0] held_d;
    logic       in_x;
    logic       out_x;
    in_valid  = v;
    addr      = a;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    exp_ov = '0;
    held_d = '0;
    if (rst) begin
      exp_rdy = 1'b0;
    end else begin
      exp_rdy = (q.size() == 0) || r[q[0].a];
      if (q.size() != 0) begin
        exp_ov[q[0].a] = 1'b1;
        held_d = q[0].d;
      end
    end
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_ov);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("outputs[%0d]", i), outs4[i], exp_ov[i] ? held_d : 8'h00);
    end
    if (!rst) begin
      check("err", err, 0);
      check("drop_cnt", drop_cnt, 0);
    end
    in_x  = v && exp_rdy;
    out_x = (exp_ov & r) != 0;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back('{a: a, d: d});
    end
  endtask

  task automatic drive3(input logic v, input logic [1:0] a, input logic [7:0] d,
                        input logic [2:0] r);
    iv3 = v;
    a3  = a;
    d3  = d;
    r3  = r;
  endtask

  task automatic next3;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held: handshake outputs forced low
    rst = 1'b1;
    step4(1'b1, 2'd1, 8'h11, 4'hF);
    step4(1'b0, 2'd0, 8'h00, 4'hF);
    rst = 1'b0;
    step4(1'b0, 2'd0, 8'h00, 4'hF);

    // Back-to-back stream, every sink ready
    for (int k = 0; k < 4; k++) begin
      step4(1'b1, 2'(3 - k), 8'(3 - k), 4'hF);
    end
    step4(1'b0, 2'd0, 8'h00, 4'hF);

    // Backpressure on destination 2 with a pending word, then drain+refill
    step4(1'b1, 2'd2, 8'hA5, 4'hF);
    for (int k = 0; k < 3; k++) begin
      step4(1'b1, 2'd0, 8'h3C, 4'h0);
    end
    step4(1'b1, 2'd0, 8'h3C, 4'b0100);
    step4(1'b0, 2'd0, 8'h00, 4'hF);

    // Held word for destination 1; other ready bits toggling do nothing
    step4(1'b1, 2'd1, 8'h5A, 4'h0);
    step4(1'b1, 2'd3, 8'hC3, 4'b1101);
    step4(1'b1, 2'd3, 8'hC3, 4'b0000);
    step4(1'b1, 2'd3, 8'hC3, 4'b1000);
    step4(1'b1, 2'd3, 8'hC3, 4'b0101);
    step4(1'b1, 2'd3, 8'hC3, 4'b1101);
    step4(1'b0, 2'd0, 8'h00, 4'hF);
    step4(1'b0, 2'd0, 8'h00, 4'hF);

    // Reset while holding a word, with an input transfer also offered
    step4(1'b1, 2'd2, 8'h77, 4'h0);
    rst = 1'b1;
    step4(1'b1, 2'd1, 8'h88, 4'hF);
    rst = 1'b0;
    step4(1'b0, 2'd0, 8'h00, 4'h0);

    // 3-destination instance: out-of-range drop
    drive3(1'b1, 2'd3, 8'h55, 3'b111);
    @(negedge clk);
    check("d3_in_ready", ir3, 1);
    check("d3_out_valid", ov3, 0);
    next3();
    drive3(1'b0, 2'd0, 8'h00, 3'b111);
    @(negedge clk);
    check("d3_err_pulse", err3, 1);
    check("d3_out_valid", ov3, 0);
    check("d3_drop_cnt", dc3, 1);
    for (int i = 0; i < 3; i++) check($sformatf("d3_outputs[%0d]", i), o3[i], 0);
    next3();
    @(negedge clk);
    check("d3_err_end", err3, 0);
    check("d3_drop_cnt", dc3, 1);
    next3();

    // In-range word held, then reloaded by an out-of-range word
    drive3(1'b1, 2'd2, 8'h99, 3'b000);
    @(negedge clk);
    check("d3_in_ready", ir3, 1);
    next3();
    drive3(1'b1, 2'd3, 8'hAA, 3'b000);
    @(negedge clk);
    check("d3_out_valid", ov3, 3'b100);
    check("d3_outputs[2]", o3[2], 8'h99);
    check("d3_in_ready", ir3, 0);
    next3();
    drive3(1'b1, 2'd3, 8'hAA, 3'b100);
    @(negedge clk);
    check("d3_in_ready", ir3, 1);
    next3();
    drive3(1'b0, 2'd0, 8'h00, 3'b000);
    @(negedge clk);
    check("d3_out_valid", ov3, 0);
    check("d3_err_reload", err3, 1);
    check("d3_drop_cnt", dc3, 2);
    next3();

    // Counter saturation
    drive3(1'b1, 2'd3, 8'h55, 3'b111);
    for (int k = 0; k < 100; k++) @(posedge clk);
    @(negedge clk);
    check("d3_drop_cnt_mid", dc3, 102);
    for (int k = 0; k < 200; k++) @(posedge clk);
    #1;
    drive3(1'b0, 2'd0, 8'h00, 3'b111);
    @(negedge clk);
    check("d3_drop_sat", dc3, 255);
    check("d3_err_last", err3, 1);
    check("d3_out_valid", ov3, 0);
    next3();
    @(negedge clk);
    check("d3_drop_hold", dc3, 255);
    next3();

    // Random traffic on the 4-destination instance
    for (int k = 0; k < 10000; k++) begin
      step4($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end
    for (int k = 0; k < 3; k++) step4(1'b0, 2'd0, 8'h00, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
